// File: rtl/class_sum_argmax.sv
// Snapshots the adder's per-class sums on a rising edge of sums_valid, then
// scans them one compare per cycle and reports the arg-max with a valid pulse.
module class_sum_argmax #(
  parameter int CLASS_NUM = 10,
  parameter int SUM_W     = 14,
  parameter int IDX_W     = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [SUM_W-1:0] class_sums [CLASS_NUM],
  input  logic                    sums_valid,
  output logic [IDX_W-1:0]        pred_class,
  output logic signed [SUM_W-1:0] pred_max,
  output logic                    pred_valid,
  output logic                    busy,
  output logic                    overrun
);

  // Handshake: sums_valid is a level with no ready. Only its rising edge
  // matters; it is captured when IDLE and flagged as overrun otherwise.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_prev_valid;
  logic signed [SUM_W-1:0] r_snap [CLASS_NUM];
  logic [IDX_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_best_idx;
  logic signed [SUM_W-1:0] r_best_val;
  logic [IDX_W-1:0]        r_pred_class;
  logic signed [SUM_W-1:0] r_pred_max;
  logic                    r_pred_valid;
  logic                    r_overrun;
  logic                    w_rise;
  logic                    w_last;
  logic                    w_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_next_state = (CLASS_NUM > 1) ? S_SCAN : S_DONE;
      S_SCAN:  if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_rise = sums_valid & ~r_prev_valid;
    w_last = (r_cnt == IDX_W'(CLASS_NUM - 1));
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      for (int i = 0; i < CLASS_NUM; i++) r_snap[i] <= '0;
      r_cnt        <= '0;
      r_best_idx   <= '0;
      r_best_val   <= '0;
      r_pred_class <= '0;
      r_pred_max   <= '0;
      r_pred_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_prev_valid <= sums_valid;
      r_pred_valid <= 1'b0;
      if (w_rise && w_busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_snap     <= class_sums;
            r_best_idx <= '0;
            r_best_val <= class_sums[0];
            r_cnt      <= IDX_W'(1);
          end
        end
        S_SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (r_snap[r_cnt] > r_best_val) begin
            r_best_idx <= r_cnt;
            r_best_val <= r_snap[r_cnt];
          end
          if (!w_last) r_cnt <= r_cnt + IDX_W'(1);
        end
        S_DONE: begin
          r_pred_class <= r_best_idx;
          r_pred_max   <= r_best_val;
          r_pred_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pred_class = r_pred_class;
  assign pred_max   = r_pred_max;
  assign pred_valid = r_pred_valid;
  assign busy       = w_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_class_sum_argmax.sv
// Bench for class_sum_argmax: vector table through a scoreboard queue, plus
// hand-written sequences for held level, overrun and reset mid-scan.
module tb_class_sum_argmax;

  localparam int CN = 10;
  localparam int SW = 14;
  localparam int IW = 4;

  typedef logic signed [SW-1:0] sum_arr_t [CN];
  typedef struct {
    sum_arr_t sums;
    int       exp_class;
    int       exp_max;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [SW-1:0] class_sums [CN];
  logic                 sums_valid;
  logic [IW-1:0]        pred_class;
  logic signed [SW-1:0] pred_max;
  logic                 pred_valid;
  logic                 busy;
  logic                 overrun;

  logic [IW+SW-1:0] exp_q [$];
  logic [IW+SW-1:0] mon_e;
  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  class_sum_argmax #(.CLASS_NUM(CN), .SUM_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .class_sums (class_sums),
    .sums_valid (sums_valid),
    .pred_class (pred_class),
    .pred_max   (pred_max),
    .pred_valid (pred_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic sum_arr_t mk(input int a [CN]);
    sum_arr_t r;
    for (int i = 0; i < CN; i++) r[i] = SW'(a[i]);
    return r;
  endfunction

  function automatic void ref_argmax(input sum_arr_t s, output int idx, output int val);
    idx = 0;
    val = int'(s[0]);
    for (int i = 1; i < CN; i++)
      if (int'(s[i]) > val) begin
        idx = i;
        val = int'(s[i]);
      end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && pred_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: class %0d max %0d with empty queue",
                 pred_class, pred_max);
      end else begin
        mon_e = exp_q.pop_front();
        check("pred_class", int'(pred_class), int'(mon_e[SW +: IW]));
        check("pred_max", int'(pred_max), int'($signed(mon_e[SW-1:0])));
      end
    end
  end

  // driver tasks
  task automatic wait_pulse(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 3 * CN + 10; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (pred_valid) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic apply(input sum_arr_t s, input int ec, input int em);
    int lat, bcnt;
    @(posedge clk); #1;
    class_sums = s;
    sums_valid = 1'b1;
    exp_q.push_back({IW'(ec), SW'(em)});
    @(posedge clk); #1;
    sums_valid = 1'b0;
    wait_pulse(lat, bcnt);
    check("latency", lat, CN);
    check("busy_cycles", bcnt, CN);
    @(negedge clk);
    check("pulse_width", int'(pred_valid), 0);
  endtask

  initial begin
    vec_t     vecs [$];
    vec_t     v;
    sum_arr_t s;
    int       lat, bcnt, p0, ei, ev;

    // reset
    rst        = 1'b1;
    sums_valid = 1'b0;
    for (int i = 0; i < CN; i++) class_sums[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pred_class", int'(pred_class), 0);
    check("rst_pred_max", int'(pred_max), 0);
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // vector table
    v.sums = mk('{5, -3, 12, 7, 0, 12, -8, 1, 2, 3});
    v.exp_class = 2; v.exp_max = 12; vecs.push_back(v);
    v.sums = mk('{-50, -9, -300, -77, -2, -8192, -40, -1, -1, -600});
    v.exp_class = 7; v.exp_max = -1; vecs.push_back(v);
    v.sums = mk('{-8192, 0, 0, 0, 0, 0, 0, 0, 0, 8191});
    v.exp_class = 9; v.exp_max = 8191; vecs.push_back(v);
    v.sums = mk('{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192});
    v.exp_class = 0; v.exp_max = -8192; vecs.push_back(v);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < CN; i++) s[i] = SW'($urandom_range(0, (1 << SW) - 1));
      ref_argmax(s, ei, ev);
      v.sums = s; v.exp_class = ei; v.exp_max = ev;
      vecs.push_back(v);
    end
    foreach (vecs[i]) apply(vecs[i].sums, vecs[i].exp_class, vecs[i].exp_max);

    // level held high for 40 cycles
    p0 = pulse_cnt;
    @(posedge clk); #1;
    class_sums = vecs[1].sums;
    sums_valid = 1'b1;
    exp_q.push_back({IW'(vecs[1].exp_class), SW'(vecs[1].exp_max)});
    repeat (40) @(posedge clk);
    #1 sums_valid = 1'b0;
    @(negedge clk);
    check("held_pulses", pulse_cnt - p0, 1);
    check("held_overrun", int'(overrun), 0);

    // overrun: re-rise during scan with a new larger max at index 1
    p0 = pulse_cnt;
    @(posedge clk); #1;
    class_sums = vecs[0].sums;
    sums_valid = 1'b1;
    exp_q.push_back({IW'(vecs[0].exp_class), SW'(vecs[0].exp_max)});
    @(posedge clk); #1;
    sums_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sums_valid    = 1'b1;
    class_sums[1] = SW'(8000);
    wait_pulse(lat, bcnt);
    check("overrun_latency", lat, CN - 3);
    check("overrun_flag", int'(overrun), 1);
    repeat (20) @(posedge clk);
    #1 sums_valid = 1'b0;
    @(negedge clk);
    check("overrun_pulses", pulse_cnt - p0, 1);
    apply(vecs[2].sums, vecs[2].exp_class, vecs[2].exp_max);
    check("overrun_sticky", int'(overrun), 1);

    // reset mid-scan
    p0 = pulse_cnt;
    @(posedge clk); #1;
    class_sums = vecs[1].sums;
    sums_valid = 1'b1;
    @(posedge clk); #1;
    sums_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_pred_valid", int'(pred_valid), 0);
    check("abort_pred_class", int'(pred_class), 0);
    check("abort_pred_max", int'(pred_max), 0);
    check("abort_overrun", int'(overrun), 0);
    repeat (15) @(negedge clk);
    check("abort_pulses", pulse_cnt - p0, 0);
    apply(vecs[3].sums, vecs[3].exp_class, vecs[3].exp_max);
    apply(vecs[1].sums, vecs[1].exp_class, vecs[1].exp_max);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
